// File: rtl/yu_pkg.sv
// Shared Yu core definitions: default widths, the zero-register index and the data word type.
package yu_pkg;
  localparam int XLEN_DEFAULT     = 32;
  localparam int NUM_REGS_DEFAULT = 32;
  localparam int REG_ZERO         = 0;

  typedef logic [XLEN_DEFAULT-1:0] word_t;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// Register-file bus between decode/writeback (master) and the register file (slave).
interface regfile_scoreboard_if
  import yu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int AW   = $clog2(NUM_REGS_DEFAULT)
) ();
  logic [AW-1:0]   ra1;
  logic [AW-1:0]   ra2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            we;
  logic [AW-1:0]   wa;
  logic [XLEN-1:0] wd;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            rs1_busy;
  logic            rs2_busy;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_data;

  modport master (
    output ra1, ra2, we, wa, wd, iss_valid, iss_rd, dbg_addr,
    input  rd1, rd2, rs1_busy, rs2_busy, dbg_data
  );

  modport slave (
    input  ra1, ra2, we, wa, wd, iss_valid, iss_rd, dbg_addr,
    output rd1, rd2, rs1_busy, rs2_busy, dbg_data
  );
endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: zero-register masking, writeback bypass and hazard masking.
module rf_read_port
  import yu_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int AW        = $clog2(NUM_REGS_DEFAULT),
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic [AW-1:0]   i_ra,
  input  logic            i_we,
  input  logic [AW-1:0]   i_wa,
  input  logic [XLEN-1:0] i_wd,
  input  logic [XLEN-1:0] i_reg,
  input  logic            i_busy,
  output logic [XLEN-1:0] o_rd,
  output logic            o_busy
);
  logic w_ra_zero;
  logic w_hit;

  assign w_ra_zero = (i_ra == AW'(REG_ZERO));
  // A retiring write to the addressed register both supplies the data and resolves the hazard.
  assign w_hit     = BYPASS_EN && i_we && (i_wa == i_ra) && (i_wa != AW'(REG_ZERO));

  assign o_rd   = w_ra_zero ? '0 : (w_hit ? i_wd : i_reg);
  assign o_busy = i_busy && !w_hit;
endmodule

// File: rtl/regfile_scoreboard.sv
// Yu core integer register file with write forwarding, per-register busy scoreboard and debug port.
module regfile_scoreboard
  import yu_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int NUM_REGS  = NUM_REGS_DEFAULT,
  parameter bit BYPASS_EN = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  regfile_scoreboard_if.slave  bus
);
  localparam int AW = $clog2(NUM_REGS);

  logic [XLEN-1:0]     r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [XLEN-1:0]     r_dbg;
  logic                w_wr_en;

  assign w_wr_en = bus.we && (bus.wa != AW'(REG_ZERO));

  // NOTE: the storage array is reset explicitly because every register must read 0 after reset;
  // this rules out RAM macro inference, which is acceptable for a flop-based register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_busy <= '0;
      r_dbg  <= '0;
    end else begin
      // NOTE: non-blocking assignments so the debug sample sees the pre-write register value.
      if (w_wr_en) r_regs[bus.wa] <= bus.wd;
      r_dbg <= (bus.dbg_addr == AW'(REG_ZERO)) ? '0 : r_regs[bus.dbg_addr];
      r_busy[0] <= 1'b0;
      // Issue wins over retire so a back-to-back reissue keeps the register busy.
      for (int i = 1; i < NUM_REGS; i++) begin
        if (bus.iss_valid && (bus.iss_rd == AW'(i)))
          r_busy[i] <= 1'b1;
        else if (bus.we && (bus.wa == AW'(i)))
          r_busy[i] <= 1'b0;
      end
    end
  end

  logic [XLEN-1:0] w_rd1, w_rd2;
  logic            w_rs1_busy, w_rs2_busy;

  rf_read_port #(.XLEN(XLEN), .AW(AW), .BYPASS_EN(BYPASS_EN)) u_rp1 (
    .i_ra   (bus.ra1),
    .i_we   (bus.we),
    .i_wa   (bus.wa),
    .i_wd   (bus.wd),
    .i_reg  (r_regs[bus.ra1]),
    .i_busy (r_busy[bus.ra1]),
    .o_rd   (w_rd1),
    .o_busy (w_rs1_busy)
  );

  rf_read_port #(.XLEN(XLEN), .AW(AW), .BYPASS_EN(BYPASS_EN)) u_rp2 (
    .i_ra   (bus.ra2),
    .i_we   (bus.we),
    .i_wa   (bus.wa),
    .i_wd   (bus.wd),
    .i_reg  (r_regs[bus.ra2]),
    .i_busy (r_busy[bus.ra2]),
    .o_rd   (w_rd2),
    .o_busy (w_rs2_busy)
  );

  assign bus.rd1      = w_rd1;
  assign bus.rd2      = w_rd2;
  assign bus.rs1_busy = w_rs1_busy;
  assign bus.rs2_busy = w_rs2_busy;
  assign bus.dbg_data = r_dbg;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: one bypassing and one non-bypassing register file driven by identical stimulus.
module tb_regfile_scoreboard;
  import yu_pkg::*;

  localparam int AW = $clog2(NUM_REGS_DEFAULT);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] ra1 = '0, ra2 = '0, wa = '0, iss_rd = '0, dbg_addr = '0;
  logic          we = 1'b0, iss_valid = 1'b0;
  word_t         wd = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.XLEN(XLEN_DEFAULT), .AW(AW)) if_a ();
  regfile_scoreboard_if #(.XLEN(XLEN_DEFAULT), .AW(AW)) if_b ();

  assign if_a.ra1 = ra1;  assign if_b.ra1 = ra1;
  assign if_a.ra2 = ra2;  assign if_b.ra2 = ra2;
  assign if_a.we  = we;   assign if_b.we  = we;
  assign if_a.wa  = wa;   assign if_b.wa  = wa;
  assign if_a.wd  = wd;   assign if_b.wd  = wd;
  assign if_a.iss_valid = iss_valid;  assign if_b.iss_valid = iss_valid;
  assign if_a.iss_rd    = iss_rd;     assign if_b.iss_rd    = iss_rd;
  assign if_a.dbg_addr  = dbg_addr;   assign if_b.dbg_addr  = dbg_addr;

  regfile_scoreboard #(.XLEN(XLEN_DEFAULT), .NUM_REGS(NUM_REGS_DEFAULT), .BYPASS_EN(1'b1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  regfile_scoreboard #(.XLEN(XLEN_DEFAULT), .NUM_REGS(NUM_REGS_DEFAULT), .BYPASS_EN(1'b0)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset and idle read
    #12 rst_n = 1'b1;
    step();
    ra1 = 5; ra2 = 31; dbg_addr = 5;
    #1;
    check("rst_rd1_a",   if_a.rd1, 32'h0);
    check("rst_rd2_a",   if_a.rd2, 32'h0);
    check("rst_busy1_a", {31'b0, if_a.rs1_busy}, 32'h0);
    check("rst_rd1_b",   if_b.rd1, 32'h0);
    step();
    check("rst_dbg_a", if_a.dbg_data, 32'h0);

    // Write to x0 is ignored, even through the bypass path
    we = 1'b1; wa = 0; wd = 32'hDEADBEEF; ra1 = 0; dbg_addr = 0;
    #1;
    check("x0_bypass_a", if_a.rd1, 32'h0);
    step();
    we = 1'b0;
    #1;
    check("x0_rd1_a", if_a.rd1, 32'h0);
    step();
    check("x0_dbg_a", if_a.dbg_data, 32'h0);

    // Same-cycle forwarding vs. pre-write value
    we = 1'b1; wa = 7; wd = 32'h12345678; ra1 = 7; ra2 = 7; dbg_addr = 7;
    #1;
    check("byp_rd1_a", if_a.rd1, 32'h12345678);
    check("byp_rd2_a", if_a.rd2, 32'h12345678);
    check("nobyp_rd1_b", if_b.rd1, 32'h0);
    check("nobyp_rd2_b", if_b.rd2, 32'h0);
    step();
    we = 1'b0;
    #1;
    check("post_rd1_b", if_b.rd1, 32'h12345678);
    check("post_rd2_a", if_a.rd2, 32'h12345678);
    check("dbg_prewrite_a", if_a.dbg_data, 32'h0);
    step();
    check("dbg_after_a", if_a.dbg_data, 32'h12345678);

    // Issue then retire: combinational clear only with bypass
    iss_valid = 1'b1; iss_rd = 3;
    step();
    iss_valid = 1'b0; ra1 = 3;
    #1;
    check("iss_busy1_a", {31'b0, if_a.rs1_busy}, 32'h1);
    check("iss_busy1_b", {31'b0, if_b.rs1_busy}, 32'h1);
    we = 1'b1; wa = 3; wd = 32'h00003333;
    #1;
    check("ret_busy1_a", {31'b0, if_a.rs1_busy}, 32'h0);
    check("ret_busy1_b", {31'b0, if_b.rs1_busy}, 32'h1);
    check("ret_rd1_a",   if_a.rd1, 32'h00003333);
    step();
    we = 1'b0;
    #1;
    check("clr_busy1_a", {31'b0, if_a.rs1_busy}, 32'h0);
    check("clr_busy1_b", {31'b0, if_b.rs1_busy}, 32'h0);

    // Simultaneous issue and retire to the same register: issue wins
    iss_valid = 1'b1; iss_rd = 9; we = 1'b1; wa = 9; wd = 32'h99990000; ra2 = 9;
    step();
    iss_valid = 1'b0; we = 1'b0;
    #1;
    check("setpri_busy2_a", {31'b0, if_a.rs2_busy}, 32'h1);
    check("setpri_busy2_b", {31'b0, if_b.rs2_busy}, 32'h1);
    check("setpri_rd2_a",   if_a.rd2, 32'h99990000);
    check("setpri_rd2_b",   if_b.rd2, 32'h99990000);

    // Issue to x0 never marks it busy
    iss_valid = 1'b1; iss_rd = 0;
    step();
    iss_valid = 1'b0; ra1 = 0;
    #1;
    check("x0_busy1_a", {31'b0, if_a.rs1_busy}, 32'h0);

    // Asynchronous reset mid-operation
    we = 1'b1; wa = 12; wd = 32'hA5A5A5A5; iss_valid = 1'b1; iss_rd = 20;
    step();
    we = 1'b0; iss_valid = 1'b0; ra1 = 12; ra2 = 20; dbg_addr = 12;
    #1;
    check("pre_rst_rd1_a",   if_a.rd1, 32'hA5A5A5A5);
    check("pre_rst_busy2_a", {31'b0, if_a.rs2_busy}, 32'h1);
    step();
    check("pre_rst_dbg_a", if_a.dbg_data, 32'hA5A5A5A5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rd1_a",   if_a.rd1, 32'h0);
    check("arst_rd1_b",   if_b.rd1, 32'h0);
    check("arst_busy2_a", {31'b0, if_a.rs2_busy}, 32'h0);
    check("arst_dbg_a",   if_a.dbg_data, 32'h0);
    // Writes and issues presented while reset is held are dropped
    we = 1'b1; wa = 12; wd = 32'h0BADF00D; iss_valid = 1'b1; iss_rd = 20;
    step();
    we = 1'b0; iss_valid = 1'b0;
    #2 rst_n = 1'b1;
    step();
    check("drop_rd1_a",   if_a.rd1, 32'h0);
    check("drop_busy2_a", {31'b0, if_a.rs2_busy}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
